// File: rtl/key_expand_pkg.sv
// Shared widths, FSM state encoding and the round-constant table for the
// AES-128 key schedule.
package key_expand_pkg;

    localparam int W_KEY  = 128;
    localparam int W_DATA = 32;

    localparam logic [3:0] ROUND_LAST = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_CALC    = 2'd2
    } state_e;

    // Round constant used while producing round key number 'round' (1..10).
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] rc;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/key_expand_sbox.sv
// Combinational AES forward S-box (8-bit lookup), shared with the SubBytes stage.
module key_expand_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry 0 is the most significant byte; one 128-bit literal per table row.
    localparam logic [0:255][7:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX_TABLE[in_i];

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: presents round keys 0..10 one at a time over a
// valid/ready handshake, computing each next key in a single CALC cycle.
module key_expand
    import key_expand_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W_KEY-1:0] key,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [W_KEY-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [W_KEY-1:0] key_q, key_d;
    logic [3:0]       idx_q, idx_d;
    logic             done_q, done_d;

    logic [W_DATA-1:0] rot_word, sub_word, t_word;
    logic [W_DATA-1:0] w0_n, w1_n, w2_n, w3_n;

    // w3 is the least significant word; RotWord moves its top byte to the bottom.
    assign rot_word = {key_q[23:0], key_q[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            key_expand_sbox u_sbox (
                .in_i  (rot_word[8*gi +: 8]),
                .out_o (sub_word[8*gi +: 8])
            );
        end
    endgenerate

    assign t_word = sub_word ^ {rcon(idx_q + 4'd1), 24'h000000};
    assign w0_n   = key_q[127:96] ^ t_word;
    assign w1_n   = key_q[95:64]  ^ w0_n;
    assign w2_n   = key_q[63:32]  ^ w1_n;
    assign w3_n   = key_q[31:0]   ^ w2_n;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key;
                    idx_d   = 4'd0;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (rk_ready) begin
                    if (idx_q == ROUND_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                key_d   = {w0_n, w1_n, w2_n, w3_n};
                idx_d   = idx_q + 4'd1;
                state_d = ST_PRESENT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid  = (state_q == ST_PRESENT);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign round_key = key_q;
    assign round_idx = idx_q;

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: a FIPS-197 style key-schedule model
// (S-box derived from GF(2^8) inversion) checked every cycle, plus directed scenarios.
module tb_key_expand;

    typedef logic [127:0] rk_arr_t [0:10];

    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] Z1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3  = 128'hffeeddccbbaa99887766554433221100;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [127:0] key;
    logic         rk_valid, busy, done;
    logic [127:0] round_key;
    logic [3:0]   round_idx;

    int checks = 0;
    int errors = 0;

    key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key       (key),
        .rk_ready  (rk_ready),
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_m(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word_m(input logic [31:0] w);
        return {sbox_m(w[31:24]), sbox_m(w[23:16]), sbox_m(w[15:8]), sbox_m(w[7:0])};
    endfunction

    function automatic void expand(input logic [127:0] k, output rk_arr_t rk);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = sub_word_m({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // ---------------- every-cycle compare process ----------------
    rk_arr_t      exp_rk;
    int           exp_idx   = 0;
    bit           exp_busy  = 0;
    bit           exp_valid = 0;
    bit           exp_calc  = 0;
    bit           done_exp  = 0;
    bit           exp_zero  = 0;
    bit           chk_en    = 0;
    logic [127:0] acc [$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", busy, exp_busy);
                check("rk_valid", rk_valid, exp_valid);
                check("done", done, done_exp);
                check("done_valid_excl", done & rk_valid, 1'b0);
                if (exp_valid) begin
                    check("round_key", round_key, exp_rk[exp_idx]);
                    check("round_idx", round_idx, exp_idx[3:0]);
                end
                if (exp_zero) begin
                    check("reset_key", round_key, 128'h0);
                    check("reset_idx", round_idx, 4'd0);
                end
            end
            if (rk_valid && rk_ready) acc.push_back(round_key);
            done_exp = 0;
            if (rst) begin
                exp_busy = 0; exp_valid = 0; exp_calc = 0; exp_idx = 0; exp_zero = 1;
            end else if (!exp_busy && start) begin
                expand(key, exp_rk);
                exp_idx = 0; exp_busy = 1; exp_valid = 1; exp_zero = 0;
            end else if (exp_calc) begin
                exp_calc = 0; exp_idx++; exp_valid = 1;
            end else if (exp_valid && rk_ready) begin
                exp_valid = 0;
                if (exp_idx == 10) begin
                    done_exp = 1; exp_busy = 0;
                end else begin
                    exp_calc = 1;
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    rk_arr_t ref_rk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_key(input logic [127:0] k);
        acc.delete();
        expand(k, ref_rk);
        start = 1'b1;
        key   = k;
        step();
        start = 1'b0;
        key   = ~k;
        check("lat_valid", rk_valid, 1'b1);
        check("lat_idx", round_idx, 4'd0);
        check("lat_key", round_key, k);
    endtask

    task automatic drain(input int stall_idx, input int pulse_idx, input logic [127:0] pulse_key);
        int hold   = 0;
        bit pulsed = 0;
        bit got    = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            start = 1'b0;
            if (rk_valid && round_idx == stall_idx[3:0] && hold < 5) begin
                rk_ready = 1'b0;
                hold++;
                check("stall_key", round_key, ref_rk[stall_idx]);
            end else begin
                rk_ready = 1'b1;
            end
            if (rk_valid && round_idx == pulse_idx[3:0] && !pulsed) begin
                start  = 1'b1;
                key    = pulse_key;
                pulsed = 1;
            end
            step();
            if (done) got = 1;
        end
        start = 1'b0;
        check("done_seen", got, 1'b1);
        check("valid_count", acc.size(), 11);
        if (acc.size() == 11) begin
            check("acc_idx10", acc[10], ref_rk[10]);
            check("acc_idx5", acc[5], ref_rk[5]);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key = '0;

        // Model pinned by hand-computed values.
        check("pin_sbox00", sbox_m(8'h00), 8'h63);
        check("pin_sbox53", sbox_m(8'h53), 8'hed);
        expand(K1, ref_rk);
        check("pin_k1_r1", ref_rk[1], R1);
        check("pin_k1_r10", ref_rk[10], R10);
        expand(128'h0, ref_rk);
        check("pin_zero_r1", ref_rk[1], Z1);

        step();
        chk_en = 1;
        check("rst_valid", rk_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_key", round_key, 128'h0);
        step();
        rst = 1'b0;

        // FIPS-197 key with continuous ready.
        start_key(K1);
        drain(99, 99, '0);
        check("k1_idx1", acc.size() > 1 ? acc[1] : 128'hx, R1);
        check("k1_idx10", acc.size() > 10 ? acc[10] : 128'hx, R10);

        // All-zero key.
        start_key(128'h0);
        drain(99, 99, '0);
        check("zero_idx1", acc.size() > 1 ? acc[1] : 128'hx, Z1);

        // Back-pressure on idx3.
        start_key(K2);
        drain(3, 99, '0);

        // Start with a different key during idx4 is ignored.
        start_key(K1);
        drain(99, 4, K3);
        check("ign_idx10", acc.size() > 10 ? acc[10] : 128'hx, R10);

        // Reset during CALC after idx6 accept.
        start_key(K3);
        rk_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (rk_valid && round_idx == 4'd6) break;
            step();
        end
        step();
        check("calc_valid", rk_valid, 1'b0);
        check("calc_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", rk_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_idx", round_idx, 4'd0);
        check("abort_key", round_key, 128'h0);
        repeat (3) step();
        start_key(K3);
        drain(99, 99, '0);

        // Start accepted in the done cycle.
        check("done_now", done, 1'b1);
        start_key(K2);
        drain(2, 99, '0);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
